// File: rtl/hram_avmm_slave_if.sv
// Bus bundle between an Avalon-MM master and the HyperRAM command bridge.
// Carries the Avalon slave port, the command slot toward the controller,
// the read-response return path and the sticky error flag.
interface hram_avmm_slave_if;
    logic [31:0] slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [3:0]  slave_byteenable;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [29:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;

    logic        rsp_valid;
    logic [31:0] rsp_data;

    logic        err_unexpected_rsp;

    // Bridge side: consumes Avalon requests and controller responses
    modport slave (
        input  slave_address, slave_read, slave_write, slave_writedata,
               slave_byteenable, cmd_ready, rsp_valid, rsp_data,
        output slave_waitrequest, slave_readdata, slave_readdatavalid,
               cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be,
               err_unexpected_rsp
    );

    // Environment side: drives Avalon requests and plays the controller
    modport master (
        output slave_address, slave_read, slave_write, slave_writedata,
               slave_byteenable, cmd_ready, rsp_valid, rsp_data,
        input  slave_waitrequest, slave_readdata, slave_readdatavalid,
               cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be,
               err_unexpected_rsp
    );
endinterface

// File: rtl/hram_avmm_slave.sv
// Avalon-MM slave to HyperRAM controller command bridge.
// A single command slot holds one command toward the controller; it can be
// refilled in the same cycle the controller takes the old one, giving one
// command per cycle. Outstanding reads are counted so that no more than
// MAX_PENDING responses can ever be owed to the Avalon master.
module hram_avmm_slave #(
    parameter int MAX_PENDING = 4
) (
    input  logic              clk_clk,
    input  logic              clk_reset_reset_n,
    hram_avmm_slave_if.slave  bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slotState_t;

    slotState_t  r_state;
    slotState_t  w_nextState;

    logic [3:0]  r_pending;
    logic        r_cmdWrite;
    logic [29:0] r_cmdAddr;
    logic [31:0] r_cmdWdata;
    logic [3:0]  r_cmdBe;
    logic        r_readDataValid;
    logic [31:0] r_readData;
    logic        r_errUnexpected;

    logic        w_slotFree;
    logic        w_readOnly;
    logic        w_pendingFull;
    logic        w_waitrequest;
    logic        w_acceptWrite;
    logic        w_acceptRead;
    logic        w_rspExpected;
    logic        w_unusedAddrBits;

    // Address bits [1:0] are byte offsets inside a word and are dropped.
    assign w_unusedAddrBits = &{1'b0, bus.slave_address[1:0]};

    assign w_slotFree    = (r_state == EMPTY) || bus.cmd_ready;
    assign w_readOnly    = bus.slave_read && !bus.slave_write;
    assign w_pendingFull = (r_pending == 4'(MAX_PENDING));
    assign w_rspExpected = bus.rsp_valid && (r_pending != 4'd0);

    // Slot state register
    always_ff @(posedge clk_clk) begin
        if (!clk_reset_reset_n) r_state <= EMPTY;
        else                    r_state <= w_nextState;
    end

    // Stall decision, acceptance qualification and slot next state
    always_comb begin
        w_waitrequest = 1'b1;
        w_acceptWrite = 1'b0;
        w_acceptRead  = 1'b0;
        w_nextState   = r_state;
        if (clk_reset_reset_n && w_slotFree && !(w_readOnly && w_pendingFull))
            w_waitrequest = 1'b0;
        w_acceptWrite = !w_waitrequest && bus.slave_write && (bus.slave_byteenable != 4'h0);
        w_acceptRead  = !w_waitrequest && w_readOnly;
        if (w_acceptWrite || w_acceptRead)
            w_nextState = FULL;
        else if ((r_state == FULL) && bus.cmd_ready)
            w_nextState = EMPTY;
    end

    // Command slot contents, loaded only when a request turns into a command
    always_ff @(posedge clk_clk) begin
        if (!clk_reset_reset_n) begin
            r_cmdWrite <= 1'b0;
            r_cmdAddr  <= 30'd0;
            r_cmdWdata <= 32'd0;
            r_cmdBe    <= 4'h0;
        end else if (w_acceptWrite) begin
            r_cmdWrite <= 1'b1;
            r_cmdAddr  <= bus.slave_address[31:2];
            r_cmdWdata <= bus.slave_writedata;
            r_cmdBe    <= bus.slave_byteenable;
        end else if (w_acceptRead) begin
            r_cmdWrite <= 1'b0;
            r_cmdAddr  <= bus.slave_address[31:2];
            r_cmdWdata <= 32'd0;
            r_cmdBe    <= 4'hF;
        end
    end

    // Outstanding read counter; a response with nothing pending is not counted
    always_ff @(posedge clk_clk) begin
        if (!clk_reset_reset_n)
            r_pending <= 4'd0;
        else if (w_acceptRead && !w_rspExpected)
            r_pending <= r_pending + 4'd1;
        else if (!w_acceptRead && w_rspExpected)
            r_pending <= r_pending - 4'd1;
    end

    // Read response return path and sticky unexpected-response flag
    always_ff @(posedge clk_clk) begin
        if (!clk_reset_reset_n) begin
            r_readDataValid <= 1'b0;
            r_readData      <= 32'd0;
            r_errUnexpected <= 1'b0;
        end else begin
            r_readDataValid <= w_rspExpected;
            if (w_rspExpected)
                r_readData <= bus.rsp_data;
            if (bus.rsp_valid && (r_pending == 4'd0))
                r_errUnexpected <= 1'b1;
        end
    end

    assign bus.slave_waitrequest   = w_waitrequest;
    assign bus.slave_readdata      = r_readData;
    assign bus.slave_readdatavalid = r_readDataValid;
    assign bus.cmd_valid           = (r_state == FULL);
    assign bus.cmd_write           = r_cmdWrite;
    assign bus.cmd_addr            = r_cmdAddr;
    assign bus.cmd_wdata           = r_cmdWdata;
    assign bus.cmd_be              = r_cmdBe;
    assign bus.err_unexpected_rsp  = r_errUnexpected;

endmodule
